// File: rtl/op_pipe_unit_if.sv
// Operand/result handshake bundle between a stimulus source, op_pipe_unit and a result sink.
interface op_pipe_unit_if #(
   parameter int W   = 4,
   parameter int REP = 2
) ();
   localparam int RW = W * REP;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          c;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] res;
   logic          err;

   modport master (
      output in_valid, a, b, c, op, out_ready,
      input  in_ready, out_valid, res, err
   );

   modport slave (
      input  in_valid, a, b, c, op, out_ready,
      output in_ready, out_valid, res, err
   );
endinterface

// File: rtl/op_pipe_unit.sv
// Two-stage pipelined operator unit: stage 1 captures operands, stage 2 holds
// the computed result until the sink takes it. Keeps a wrapping count of
// accepted operations.
module op_pipe_unit #(
   parameter int W   = 4,
   parameter int REP = 2,
   parameter int CW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   op_pipe_unit_if.slave bus,
   output logic [CW-1:0] cnt
);
   localparam int RW = W * REP;

   localparam logic [2:0] OP_LE   = 3'd0;
   localparam logic [2:0] OP_LAND = 3'd1;
   localparam logic [2:0] OP_BOR  = 3'd2;
   localparam logic [2:0] OP_REPL = 3'd3;
   localparam logic [2:0] OP_CAT  = 3'd4;
   localparam logic [2:0] OP_BAND = 3'd5;
   localparam logic [2:0] OP_BXOR = 3'd6;

   // Result evaluation; returns {err, res}. Opcode 7 is reserved and flags err.
   function automatic logic [RW:0] eval_op(
      input logic [W-1:0] a_i,
      input logic [W-1:0] b_i,
      input logic         c_i,
      input logic [2:0]   op_i
   );
      logic [RW-1:0] r;
      logic          e;
      r = {RW{1'b0}};
      e = 1'b0;
      case (op_i)
         OP_LE:   r = {{(RW-1){1'b0}}, (a_i <= b_i)};
         OP_LAND: r = {{(RW-1){1'b0}}, ((a_i != {W{1'b0}}) && (b_i != {W{1'b0}}))};
         OP_BOR:  r = {{(RW-W){1'b0}}, (a_i | b_i)};
         OP_REPL: r = {REP{a_i}};
         OP_CAT:  r = {{(RW-W-1){1'b0}}, a_i, c_i};
         OP_BAND: r = {{(RW-W){1'b0}}, (a_i & b_i)};
         OP_BXOR: r = {{(RW-W){1'b0}}, (a_i ^ b_i)};
         default: begin
            r = {RW{1'b0}};
            e = 1'b1;
         end
      endcase
      return {e, r};
   endfunction

   logic          v1_r;
   logic [W-1:0]  a1_r;
   logic [W-1:0]  b1_r;
   logic          c1_r;
   logic [2:0]    op1_r;
   logic          v2_r;
   logic [RW-1:0] res_r;
   logic          err_r;
   logic [CW-1:0] cnt_r;

   logic          s2_adv_s;
   logic          s1_adv_s;
   logic          in_ready_s;
   logic          accept_s;
   logic [RW-1:0] res_nxt_s;
   logic          err_nxt_s;

   // Advance/accept decisions and stage-2 result computation.
   always_comb begin
      s2_adv_s   = !v2_r || bus.out_ready;
      s1_adv_s   = !v1_r || s2_adv_s;
      in_ready_s = !rst && s1_adv_s;
      accept_s   = bus.in_valid && in_ready_s;
      {err_nxt_s, res_nxt_s} = eval_op(a1_r, b1_r, c1_r, op1_r);
   end

   // Stage 1: capture operands when the stage is free to move.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r  <= 1'b0;
         a1_r  <= {W{1'b0}};
         b1_r  <= {W{1'b0}};
         c1_r  <= 1'b0;
         op1_r <= 3'd0;
      end else if (s1_adv_s) begin
         v1_r <= accept_s;
         if (accept_s) begin
            a1_r  <= bus.a;
            b1_r  <= bus.b;
            c1_r  <= bus.c;
            op1_r <= bus.op;
         end else begin
            op1_r <= op1_r;
         end
      end else begin
         v1_r <= v1_r;
      end
   end

   // Stage 2: load a new result only when stage 1 holds one; hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r  <= 1'b0;
         res_r <= {RW{1'b0}};
         err_r <= 1'b0;
      end else if (s2_adv_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            res_r <= res_nxt_s;
            err_r <= err_nxt_s;
         end else begin
            res_r <= res_r;
         end
      end else begin
         v2_r <= v2_r;
      end
   end

   // Accepted-operation counter, wraps naturally at 2^CW.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = v2_r;
   assign bus.res       = res_r;
   assign bus.err       = err_r;
   assign cnt           = cnt_r;
endmodule

// File: tb/tb_op_pipe_unit.sv
// Self-checking bench for op_pipe_unit with a queue-based reference model.
module tb_op_pipe_unit;
   localparam int W   = 4;
   localparam int REP = 2;
   localparam int CW  = 3;
   localparam int RW  = W * REP;

   typedef struct {
      logic [RW-1:0] res;
      logic          err;
      int            age;
   } item_t;

   logic          clk;
   logic          rst;
   logic [CW-1:0] dut_cnt;

   op_pipe_unit_if #(.W(W), .REP(REP)) ifc ();

   op_pipe_unit #(.W(W), .REP(REP), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave),
      .cnt (dut_cnt)
   );

   int            total;
   int            bad;
   item_t         q[$];
   logic [CW-1:0] m_cnt;
   logic [RW-1:0] m_res;
   logic          m_err;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog in case something stalls beyond every bounded loop.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // Reference operator semantics using plain integer arithmetic.
   function automatic void ref_op(input int a, input int b, input int c, input int op,
                                  output logic [RW-1:0] r, output logic e);
      int v;
      e = 1'b0;
      case (op)
         0: v = (a <= b) ? 1 : 0;
         1: v = (a != 0 && b != 0) ? 1 : 0;
         2: v = a | b;
         3: begin
            v = 0;
            for (int k = 0; k < REP; k++) v = v * (1 << W) + a;
         end
         4: v = a * 2 + c;
         5: v = a & b;
         6: v = a ^ b;
         default: begin
            v = 0;
            e = 1'b1;
         end
      endcase
      r = RW'(v);
   endfunction

   // At most two operations in flight; a full unit frees a slot only if the sink takes one.
   function automatic logic model_in_ready();
      return !rst && (q.size() < 2 || ifc.out_ready);
   endfunction

   function automatic logic model_out_valid();
      return q.size() > 0 && q[0].age >= 1;
   endfunction

   // One clock edge: advance DUT and reference model together.
   task automatic tick(output logic acc);
      logic  pop;
      item_t it;
      pop = !rst && model_out_valid() && ifc.out_ready;
      acc = !rst && ifc.in_valid && model_in_ready();
      if (acc) ref_op(int'(ifc.a), int'(ifc.b), int'(ifc.c), int'(ifc.op), it.res, it.err);
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_cnt = '0;
         m_res = '0;
         m_err = 1'b0;
         acc   = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
         if (acc) begin
            it.age = 0;
            q.push_back(it);
            m_cnt = m_cnt + 1'b1;
         end
         if (model_out_valid()) begin
            m_res = q[0].res;
            m_err = q[0].err;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [2:0] op);
      ifc.in_valid = v;
      ifc.a        = a;
      ifc.b        = b;
      ifc.c        = c;
      ifc.op       = op;
   endtask

   task automatic test_reset();
      logic acc;
      rst = 1'b1;
      ifc.out_ready = 1'b1;
      drive(1'b1, 4'hF, 4'hF, 1'b1, 3'd3);
      tick(acc);
      tick(acc);
      total++;
      if ({ifc.out_valid, ifc.res, ifc.err, dut_cnt} !== {1'b0, {RW{1'b0}}, 1'b0, {CW{1'b0}}}) begin
         bad++;
         $display("FAIL reset_state: got v=%b res=%h err=%b cnt=%0d want 0 0 0 0",
                  ifc.out_valid, ifc.res, ifc.err, dut_cnt);
      end
      total++;
      if (ifc.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready);
      end
      rst = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
   endtask

   // Directed operands with hand-computed results and exact 2-cycle latency.
   task automatic run_directed(input string name, input int n,
                               input logic [3:0] ta[8], input logic [3:0] tb[8], input logic tc[8],
                               input logic [2:0] to[8], input logic [7:0] tr[8], input logic te[8]);
      logic acc;
      for (int i = 0; i < n; i++) begin
         ifc.out_ready = 1'b1;
         drive(1'b1, ta[i], tb[i], tc[i], to[i]);
         tick(acc);
         drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
         total++;
         if (ifc.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early[%0d]: got out_valid=%b want 0", name, i, ifc.out_valid);
         end
         tick(acc);
         total++;
         if ({ifc.out_valid, ifc.res, ifc.err} !== {1'b1, tr[i], te[i]}) begin
            bad++;
            $display("FAIL %s[%0d]: got v=%b res=%b err=%b want v=1 res=%b err=%b",
                     name, i, ifc.out_valid, ifc.res, ifc.err, tr[i], te[i]);
         end
      end
      tick(acc);
   endtask

   task automatic test_basic_ops();
      logic [3:0] ta[8] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b0, 4'b0};
      logic [3:0] tb[8] = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b0, 4'b0};
      logic       tc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0] to[8] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1, 3'd1, 3'd0, 3'd0};
      logic [7:0] tr[8] = '{8'h01, 8'h0F, 8'hAA, 8'h0B, 8'h01, 8'h00, 8'h00, 8'h00};
      logic       te[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      run_directed("basic_op", 6, ta, tb, tc, to, tr, te);
   endtask

   task automatic test_reserved();
      logic [3:0] ta[8] = '{4'b1111, 4'b1100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
      logic [3:0] tb[8] = '{4'b0000, 4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
      logic       tc[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] to[8] = '{3'd7, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      logic [7:0] tr[8] = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      logic       te[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      run_directed("reserved", 2, ta, tb, tc, to, tr, te);
   endtask

   task automatic test_backpressure();
      logic [2:0] ops[3] = '{3'd0, 3'd5, 3'd6};
      logic       acc;
      int         idx;
      int         popped;
      idx = 0;
      popped = 0;
      ifc.out_ready = 1'b0;
      for (int cyc = 0; cyc < 20 && (idx < 3 || q.size() > 0); cyc++) begin
         if (cyc == 4) ifc.out_ready = 1'b1;
         if (idx < 3) drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), ops[idx]);
         else drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
         #1;
         total++;
         if (ifc.in_ready !== model_in_ready()) begin
            bad++;
            $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, ifc.in_ready, model_in_ready());
         end
         if (ifc.out_valid && ifc.out_ready) popped++;
         tick(acc);
         if (acc) idx++;
         total++;
         if ({ifc.out_valid, ifc.res, ifc.err, dut_cnt} !== {model_out_valid(), m_res, m_err, m_cnt}) begin
            bad++;
            $display("FAIL bp_out[%0d]: got v=%b res=%h err=%b cnt=%0d want v=%b res=%h err=%b cnt=%0d",
                     cyc, ifc.out_valid, ifc.res, ifc.err, dut_cnt,
                     model_out_valid(), m_res, m_err, m_cnt);
         end
         if (cyc == 3) begin
            total++;
            if (ifc.in_ready !== 1'b0) begin
               bad++;
               $display("FAIL bp_full: got in_ready=%b want 0", ifc.in_ready);
            end
         end
      end
      total++;
      if (popped != 3 || ifc.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain: got popped=%0d out_valid=%b want 3 0", popped, ifc.out_valid);
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
   endtask

   task automatic test_counter_wrap();
      logic       acc;
      logic [2:0] want;
      rst = 1'b1;
      tick(acc);
      rst = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom_range(0, 6)));
         tick(acc);
         want = 3'(i % 8);
         total++;
         if (dut_cnt !== want) begin
            bad++;
            $display("FAIL cnt_wrap[%0d]: got %0d want %0d", i, dut_cnt, want);
         end
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
      tick(acc);
      tick(acc);
      ifc.out_ready = 1'b0;
      drive(1'b1, 4'h3, 4'h5, 1'b0, 3'd6);
      tick(acc);
      tick(acc);
      tick(acc);
      tick(acc);
      #1;
      total++;
      if ({ifc.in_ready, dut_cnt} !== {1'b0, 3'd3}) begin
         bad++;
         $display("FAIL cnt_blocked: got in_ready=%b cnt=%0d want 0 3", ifc.in_ready, dut_cnt);
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
      ifc.out_ready = 1'b1;
      tick(acc);
      tick(acc);
      tick(acc);
   endtask

   task automatic test_reset_midflight();
      logic acc;
      ifc.out_ready = 1'b0;
      drive(1'b1, 4'h9, 4'h2, 1'b1, 3'd2);
      tick(acc);
      drive(1'b1, 4'h6, 4'h1, 1'b0, 3'd3);
      tick(acc);
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
      total++;
      if (ifc.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_loaded: got out_valid=%b want 1", ifc.out_valid);
      end
      rst = 1'b1;
      tick(acc);
      total++;
      if ({ifc.out_valid, dut_cnt} !== {1'b0, 3'd0}) begin
         bad++;
         $display("FAIL mid_reset: got out_valid=%b cnt=%0d want 0 0", ifc.out_valid, dut_cnt);
      end
      rst = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(acc);
         total++;
         if (ifc.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_flushed[%0d]: got out_valid=%b res=%h want 0", i, ifc.out_valid, ifc.res);
         end
      end
   endtask

   task automatic test_random();
      logic acc;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 79) == 0);
         ifc.out_ready = ($urandom_range(0, 2) != 0);
         drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
               3'($urandom));
         #1;
         total++;
         if (ifc.in_ready !== model_in_ready()) begin
            bad++;
            $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, ifc.in_ready, model_in_ready());
         end
         tick(acc);
         total++;
         if ({ifc.out_valid, ifc.res, ifc.err, dut_cnt} !== {model_out_valid(), m_res, m_err, m_cnt}) begin
            bad++;
            $display("FAIL rnd_out[%0d]: got v=%b res=%h err=%b cnt=%0d want v=%b res=%h err=%b cnt=%0d",
                     cyc, ifc.out_valid, ifc.res, ifc.err, dut_cnt,
                     model_out_valid(), m_res, m_err, m_cnt);
         end
      end
      rst = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
   endtask

   // Test sequence.
   initial begin
      total = 0;
      bad   = 0;
      m_cnt = '0;
      m_res = '0;
      m_err = 1'b0;
      rst   = 1'b1;
      ifc.out_ready = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
      test_reset();
      test_basic_ops();
      test_reserved();
      test_backpressure();
      test_counter_wrap();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
